wallace_mul_pipe: RTL and testbench
===================================

Name: wallace_mul_pipe

Overview:
- Parametrised unsigned WIDTH x WIDTH multiplier built as a Wallace-tree reduction, split into 3 registered pipeline stages, with valid/ready handshakes on input and output.
- Successor to the team's fixed 4x4 combinational digit multiplier. Sits between the question/operand generator and the answer-checking logic of the flash-card datapath.
- Accepts one operand pair per cycle at full throughput. Stalls cleanly under downstream backpressure.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16; product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair a/b present
- in_ready  out  1  block can accept a/b this cycle
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- out_valid  out  1  p holds a completed product
- out_ready  in  1  consumer takes p this cycle
- p  out  2*WIDTH  product a*b
- inflight  out  2  number of occupied stages (0..3)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - v1, v2, v3 = 0; p = 0; inflight = 0; in_ready = 1.
  - Data registers need not be reset. p itself must read 0 out of reset.
- Stage 1 (S1):
  - Partial products pp_i = a & {WIDTH{b[i]}}, then the first Wallace layer of half/full adders.
  - Result registered with valid v1.
- Stage 2 (S2):
  - Remaining Wallace layers reduce the operand matrix to two rows (sum and carry vectors, each 2*WIDTH bits).
  - Result registered with valid v2.
- Stage 3 (S3):
  - Final carry-propagate add of the two rows.
  - Registered into p with v3; out_valid = v3.
- Advance rules:
  - adv3 = !v3 | out_ready
  - adv2 = !v2 | adv3
  - adv1 = !v1 | adv2
  - in_ready = adv1
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage update: on a cycle where advk is true, stage k loads the upstream stage's data and valid. Stage 1 loads from the input transfer; with no input transfer, v1 loads 0. When advk is false, stage k holds.
- Latency and throughput:
  - Latency is exactly 3 cycles from input transfer to out_valid when unstalled.
  - Throughput is 1 product per cycle.
- Bubbles: empty stages are collapsed by the advance rules. A bubble ahead of a stalled stage lets upstream data move forward.
- Stall: while out_valid & !out_ready, p and out_valid hold stable. No product is dropped or duplicated, and ordering is strictly FIFO.
- Simultaneous output and input transfer with all 3 stages full: allowed. in_ready is high because adv chains through out_ready, and occupancy stays 3.
- in_ready path: in_ready depends combinationally on out_ready and the valid bits only, never on in_valid.
- inflight = v1+v2+v3, registered consistently with the valids (no extra lag).
- Arithmetic:
  - Exact: p = a*b.
  - The maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits, so there is no overflow.
  - Carries out of bit 2*WIDTH-1 are provably 0.
- Reset mid-operation: asserting rst_n low at any time flushes all stages immediately. out_valid drops asynchronously and in-flight products are lost.

Optional Feature:
- Macro: WALLACE_MUL_SIGNED_EN.
- Defined:
  - a, b and p are two's complement.
  - Partial-product rows use Baugh-Wooley sign handling: invert the MSB terms and add correction ones at bit WIDTH and bit 2*WIDTH-1.
  - p = signed(a)*signed(b) in 2*WIDTH bits.
  - Latency, handshake and port list are unchanged.
- Undefined: unsigned behaviour as specified above.

Test Plan:
- WIDTH=4, out_ready=1, single transfer a=9, b=9 -> out_valid exactly 3 cycles later with p=8'd81; inflight goes 1,1,1,0 over that interval.
- WIDTH=4, stream all 100 pairs a,b in 0..9 back-to-back with in_valid=1 and out_ready=1 -> in_ready stays 1; 100 products in order, first at cycle 3, one per cycle; each equals a*b.
- WIDTH=4, send 3 pairs (2*3, 7*8, 15*15), hold out_ready=0 for 6 cycles -> in_ready=0 once inflight=3; p holds 6 with out_valid=1; on release, outputs 6, 56, 225 on consecutive cycles.
- WIDTH=4, inputs on cycles 0 and 2 (bubble) with out_ready=0 from cycle 3 -> the bubble collapses and both products are held in S3/S2; no loss; inflight=2.
- WIDTH=8, a=255, b=255 -> p=16'd65025. Then assert rst_n=0 with 2 products in flight -> out_valid=0, p=0, inflight=0 immediately; no stale product after rst_n returns high.
- WIDTH=4 with WALLACE_MUL_SIGNED_EN: a=4'hB (-5), b=4'h3 -> p=8'hF1 (-15); a=4'h8, b=4'h8 (-8*-8) -> p=8'h40.

Source files
------------

// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready handshakes.
// Define WALLACE_MUL_SIGNED_EN for two's-complement operands (Baugh-Wooley partial products).
module wallace_mul_pipe #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [1:0]           inflight
);

  localparam int PW = 2 * WIDTH;
`ifdef WALLACE_MUL_SIGNED_EN
  localparam int R0 = WIDTH + 1;  // extra row carries the Baugh-Wooley correction ones
`else
  localparam int R0 = WIDTH;
`endif

  function automatic int rows_after(input int n, input int layers);
    int r;
    r = n;
    for (int l = 0; l < layers; l++) r = (r / 3) * 2 + r % 3;
    return r;
  endfunction

  function automatic int layer_count(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int k = 0; k < 16; k++) begin
      if (r > 2) begin
        r = (r / 3) * 2 + r % 3;
        l++;
      end
    end
    return l;
  endfunction

  localparam int NL = layer_count(R0);
  localparam int L2 = (NL > 1) ? NL - 1 : 0;

  typedef logic [R0-1:0][PW-1:0] rows_t;

  // One Wallace layer: each group of three rows becomes a sum row and a shifted carry row;
  // leftover rows pass through unchanged behind the new pairs.
  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o;
    int    nt;
    o  = '0;
    nt = n / 3;
    for (int t = 0; t < R0 / 3; t++) begin
      if (t < nt) begin
        o[2*t]   = r[3*t] ^ r[3*t+1] ^ r[3*t+2];
        o[2*t+1] = ((r[3*t] & r[3*t+1]) | (r[3*t] & r[3*t+2]) | (r[3*t+1] & r[3*t+2])) << 1;
      end
    end
    for (int t = 0; t < R0; t++) begin
      if (t >= 3 * nt && t < n) o[t-nt] = r[t];
    end
    return o;
  endfunction

  function automatic logic [PW-1:0] get_row(input rows_t r, input int i);
    return r[i];
  endfunction

  logic            v1_q, v2_q, v3_q;
  logic            v1_d, v2_d, v3_d;
  logic            adv1, adv2, adv3;
  rows_t           pp_rows;
  rows_t           s1_rows_d, s1_rows_q;
  rows_t           lay2 [0:L2];
  logic [PW-1:0]   s2_sum_d, s2_carry_d, s2_sum_q, s2_carry_q;
  logic [PW-1:0]   p_d, p_q;

  assign adv3     = !v3_q | out_ready;
  assign adv2     = !v2_q | adv3;
  assign adv1     = !v1_q | adv2;
  assign in_ready = adv1;

  assign v1_d = adv1 ? in_valid : v1_q;
  assign v2_d = adv2 ? v1_q : v2_q;
  assign v3_d = adv3 ? v2_q : v3_q;

  always_comb begin
    pp_rows = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
`ifdef WALLACE_MUL_SIGNED_EN
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pp_rows[i][i+j] = ~(a[j] & b[i]);
        else                                      pp_rows[i][i+j] = a[j] & b[i];
`else
        pp_rows[i][i+j] = a[j] & b[i];
`endif
      end
    end
`ifdef WALLACE_MUL_SIGNED_EN
    pp_rows[WIDTH][WIDTH]  = 1'b1;
    pp_rows[WIDTH][PW-1]   = 1'b1;
`endif
  end

  assign s1_rows_d = (NL > 0) ? csa_layer(pp_rows, R0) : pp_rows;

  assign lay2[0] = s1_rows_q;
  genvar gi;
  generate
    for (gi = 0; gi < L2; gi++) begin : g_layer
      assign lay2[gi+1] = csa_layer(lay2[gi], rows_after(R0, gi + 1));
    end
  endgenerate

  assign s2_sum_d   = get_row(lay2[L2], 0);
  assign s2_carry_d = get_row(lay2[L2], 1);

  // Carries past bit PW-1 are zero (unsigned) or modular (signed), so truncation is exact.
  assign p_d = (adv3 && v2_q) ? (s2_sum_q + s2_carry_q) : p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      p_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      p_q  <= p_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) s1_rows_q <= s1_rows_d;
    if (adv2 && v1_q) begin
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
    end
  end

  assign out_valid = v3_q;
  assign p         = p_q;
  assign inflight  = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench for wallace_mul_pipe at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_wallace_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst8_n;
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic [1:0]  inflight4;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [1:0]  inflight8;

  wallace_mul_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .inflight(inflight4)
  );

  wallace_mul_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .inflight(inflight8)
  );

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } item_t;

  item_t q4[$];
  item_t q8[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    n_out4 = 0;
  bit    lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y);
    int xi, yi;
`ifdef WALLACE_MUL_SIGNED_EN
    xi = $signed(x);
    yi = $signed(y);
`else
    xi = int'(x);
    yi = int'(y);
`endif
    return 8'(xi * yi);
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
    int xi, yi;
`ifdef WALLACE_MUL_SIGNED_EN
    xi = $signed(x);
    yi = $signed(y);
`else
    xi = int'(x);
    yi = int'(y);
`endif
    return 16'(xi * yi);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input side: every accepted pair pushes its expected product.
  always @(negedge clk) begin
    if (rst_n && in_valid4 && in_ready4) q4.push_back('{16'(model4(a4, b4)), cyc});
    if (rst8_n && in_valid8 && in_ready8) q8.push_back('{model8(a8, b8), cyc});
  end

  // Output side: every taken product is compared with the oldest outstanding expectation.
  always @(negedge clk) begin
    item_t it;
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w4 unexpected output: got %0d expected none", p4);
      end else begin
        it = q4.pop_front();
        chk("w4 product", 32'(p4), 32'(it.exp[7:0]));
        if (lat_chk) chk("w4 latency", 32'(cyc - it.acc), 32'd3);
        $display("w4 out p=%0d exp=%0d", p4, it.exp[7:0]);
      end
      n_out4++;
    end
    if (rst8_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w8 unexpected output: got %0d expected none", p8);
      end else begin
        it = q8.pop_front();
        chk("w8 product", 32'(p8), 32'(it.exp));
        $display("w8 out p=%0d exp=%0d", p8, it.exp);
      end
    end
  end

  initial begin
    logic [3:0] ra, rb, sa, sb;
    logic [7:0] xa, xb;
    int         n_before;

    rst_n = 1'b0; rst8_n = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    #12;
    chk("reset out_valid", 32'(out_valid4), 32'd0);
    chk("reset p", 32'(p4), 32'd0);
    chk("reset inflight", 32'(inflight4), 32'd0);
    chk("reset in_ready", 32'(in_ready4), 32'd1);
    chk("reset p w8", 32'(p8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rst8_n = 1'b1;

    // Single transfer 9*9 with the inflight profile 1,1,1,0.
    lat_chk = 1'b1;
    tick();
    a4 = 4'd9; b4 = 4'd9; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    chk("single inflight c1", 32'(inflight4), 32'd1);
    chk("single out_valid c1", 32'(out_valid4), 32'd0);
    tick();
    chk("single inflight c2", 32'(inflight4), 32'd1);
    chk("single out_valid c2", 32'(out_valid4), 32'd0);
    tick();
    chk("single out_valid c3", 32'(out_valid4), 32'd1);
    chk("single inflight c3", 32'(inflight4), 32'd1);
    chk("single p", 32'(p4), 32'(model4(4'd9, 4'd9)));
    tick();
    chk("single inflight c4", 32'(inflight4), 32'd0);
    chk("single out_valid c4", 32'(out_valid4), 32'd0);

    // Back-to-back stream of all 0..9 x 0..9 pairs.
    n_before = n_out4;
    for (int ai = 0; ai < 10; ai++) begin
      for (int bi = 0; bi < 10; bi++) begin
        a4 = 4'(ai); b4 = 4'(bi); in_valid4 = 1'b1;
        #1;
        chk("stream in_ready", 32'(in_ready4), 32'd1);
        tick();
      end
    end
    in_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("stream count", 32'(n_out4 - n_before), 32'd100);
    lat_chk = 1'b0;

    // Three pairs then downstream stall for 6 cycles.
    out_ready4 = 1'b0;
    a4 = 4'd2;  b4 = 4'd3;  in_valid4 = 1'b1; tick();
    a4 = 4'd7;  b4 = 4'd8;  tick();
    a4 = 4'd15; b4 = 4'd15; tick();
    in_valid4 = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("stall in_ready", 32'(in_ready4), 32'd0);
      chk("stall inflight", 32'(inflight4), 32'd3);
      chk("stall out_valid", 32'(out_valid4), 32'd1);
      chk("stall p hold", 32'(p4), 32'(model4(4'd2, 4'd3)));
      tick();
    end
    out_ready4 = 1'b1;
    tick();
    chk("release p2", 32'(p4), 32'(model4(4'd7, 4'd8)));
    chk("release valid2", 32'(out_valid4), 32'd1);
    tick();
    chk("release p3", 32'(p4), 32'(model4(4'd15, 4'd15)));
    tick();
    chk("release drained", 32'(out_valid4), 32'd0);
    chk("release inflight", 32'(inflight4), 32'd0);

    // Bubble between two inputs, then stall: the bubble must collapse.
    ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
    sa = 4'($urandom_range(0, 15)); sb = 4'($urandom_range(0, 15));
    a4 = ra; b4 = rb; in_valid4 = 1'b1; tick();
    in_valid4 = 1'b0; tick();
    a4 = sa; b4 = sb; in_valid4 = 1'b1; tick();
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    tick();
    tick();
    chk("bubble inflight", 32'(inflight4), 32'd2);
    chk("bubble in_ready", 32'(in_ready4), 32'd1);
    chk("bubble out_valid", 32'(out_valid4), 32'd1);
    chk("bubble p hold", 32'(p4), 32'(model4(ra, rb)));
    out_ready4 = 1'b1;
    for (int k = 0; k < 4; k++) tick();

`ifdef WALLACE_MUL_SIGNED_EN
    a4 = 4'hB; b4 = 4'h3; in_valid4 = 1'b1; tick();
    a4 = 4'h8; b4 = 4'h8; tick();
    in_valid4 = 1'b0; tick();
    chk("signed -5*3", 32'(p4), 32'h0F1);
    tick();
    chk("signed -8*-8", 32'(p4), 32'h040);
    tick();
`endif

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid4  = ($urandom_range(0, 3) != 0);
      a4         = 4'($urandom_range(0, 15));
      b4         = 4'($urandom_range(0, 15));
      out_ready4 = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("w4 scoreboard drained", 32'(q4.size()), 32'd0);

    // WIDTH=8 maximum operands.
    a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1; tick();
    in_valid8 = 1'b0; tick(); tick();
`ifdef WALLACE_MUL_SIGNED_EN
    chk("w8 max", 32'(p8), 32'd1);
`else
    chk("w8 max", 32'(p8), 32'd65025);
`endif
    for (int k = 0; k < 80; k++) begin
      in_valid8  = ($urandom_range(0, 3) != 0);
      a8         = 8'($urandom_range(0, 255));
      b8         = 8'($urandom_range(0, 255));
      out_ready8 = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("w8 scoreboard drained", 32'(q8.size()), 32'd0);

    // Reset with two products held in the pipe.
    out_ready8 = 1'b0;
    xa = 8'($urandom_range(1, 255)); xb = 8'($urandom_range(1, 255));
    a8 = xa; b8 = xb; in_valid8 = 1'b1; tick();
    a8 = xb; b8 = xa; tick();
    in_valid8 = 1'b0;
    tick();
    chk("w8 pre-reset inflight", 32'(inflight8), 32'd2);
    chk("w8 pre-reset out_valid", 32'(out_valid8), 32'd1);
    #1;
    rst8_n = 1'b0;
    #1;
    chk("w8 async reset out_valid", 32'(out_valid8), 32'd0);
    chk("w8 async reset p", 32'(p8), 32'd0);
    chk("w8 async reset inflight", 32'(inflight8), 32'd0);
    q8.delete();
    tick();
    @(negedge clk);
    rst8_n = 1'b1;
    out_ready8 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("w8 no stale product", 32'(out_valid8), 32'd0);
    end

    chk("w4 queue empty at end", 32'(q4.size()), 32'd0);
    chk("w8 queue empty at end", 32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
